uart_rx_engine: RTL and testbench

UART receive engine, the receive-side counterpart of the transmit path. Detects the start bit on the serial line and times every bit from BAUD, using the same bit-period rule as the transmit bit-time counter. Samples each bit at mid-period and shifts the bits in LSB-first. Presents the received byte with ready, parity, framing and overrun status to the register interface, and holds it until the host issues a read-clear.

---
 rtl/uart_rx_engine.sv | 157 +++++++++++++++
 tb/tb_uart_rx_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// UART receive engine: start detection, mid-bit sampling, LSB-first shift, parity/framing/overrun status.
// Optional: define UART_RX_SYNC_EN to pass RX through a two-flop synchronizer (+2 clocks on every sample).
module uart_rx_engine #(
    parameter int BAUD_W = 19
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RX,
    input  logic [BAUD_W-1:0] BAUD,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic              READ_CLR,
    output logic [7:0]        RX_DATA,
    output logic              RXRDY,
    output logic              PERR,
    output logic              FERR,
    output logic              OVF
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [BAUD_W-1:0] CNT_ONE = 1;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] cnt_reg;
    logic [3:0]        bit_idx_reg;
    logic [8:0]        shift_reg;
    logic              eight_reg, pen_reg, ohel_reg;
    logic              rx_s;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], RX};
        end
    end

    assign rx_s = sync_reg[1];
`else
    assign rx_s = RX;
`endif

    logic [BAUD_W-1:0] half_baud;
    logic [3:0]        nbits;
    logic              at_half, at_baud, last_bit;

    assign half_baud = BAUD >> 1;
    assign nbits     = (eight_reg ? 4'd8 : 4'd7) + {3'b000, pen_reg};
    assign at_half   = (cnt_reg == half_baud);
    assign at_baud   = (cnt_reg == BAUD);
    assign last_bit  = (bit_idx_reg == nbits - 4'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // STOP exits at mid-stop so a back-to-back start edge is never missed
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!rx_s) state_next = START;
            START:   if (at_half) state_next = rx_s ? IDLE : DATA;
            DATA:    if (at_baud && last_bit) state_next = STOP;
            STOP:    if (at_baud) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic start_det, data_sample, load;

    always_comb begin
        start_det   = 1'b0;
        data_sample = 1'b0;
        load        = 1'b0;
        case (state_reg)
            IDLE:    start_det   = ~rx_s;
            DATA:    data_sample = at_baud;
            STOP:    load        = at_baud;
            default: ;
        endcase
    end

    // Restarting on every data sample makes each DATA bit a fresh BAUD+1 period
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (state_next != state_reg || data_sample || state_reg == IDLE) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            eight_reg   <= 1'b0;
            pen_reg     <= 1'b0;
            ohel_reg    <= 1'b0;
        end else if (start_det) begin
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            eight_reg   <= EIGHT;
            pen_reg     <= PEN;
            ohel_reg    <= OHEL;
        end else if (data_sample) begin
            bit_idx_reg <= bit_idx_reg + 4'd1;
            shift_reg   <= {rx_s, shift_reg[8:1]};
        end
    end

    logic [8:0] aligned;
    logic [7:0] char_data;
    logic       parity_bit, perr_calc;

    // Bits enter at the top, so the first bit ends up at position 9-N
    assign aligned    = shift_reg >> (4'd9 - nbits);
    assign char_data  = eight_reg ? aligned[7:0] : {1'b0, aligned[6:0]};
    assign parity_bit = eight_reg ? aligned[8] : aligned[7];
    assign perr_calc  = pen_reg & ((^char_data ^ parity_bit) != ohel_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RX_DATA <= '0;
            RXRDY   <= 1'b0;
            PERR    <= 1'b0;
            FERR    <= 1'b0;
            OVF     <= 1'b0;
        end else if (load) begin
            RX_DATA <= char_data;
            RXRDY   <= 1'b1;
            PERR    <= perr_calc;
            FERR    <= ~rx_s;
            OVF     <= RXRDY & ~READ_CLR;
        end else if (READ_CLR) begin
            RXRDY   <= 1'b0;
            PERR    <= 1'b0;
            FERR    <= 1'b0;
            OVF     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed vector table, hand-written corner sequences,
// and randomized frames checked against a line-level reference model.
module tb_uart_rx_engine;
`ifdef UART_RX_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RX = 1'b1;
    logic [18:0] BAUD = '0;
    logic        EIGHT = 1'b1;
    logic        PEN = 1'b0;
    logic        OHEL = 1'b0;
    logic        READ_CLR = 1'b0;
    logic [7:0]  RX_DATA;
    logic        RXRDY, PERR, FERR, OVF;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_engine #(.BAUD_W(19)) dut (
        .clk      (clk),
        .reset    (reset),
        .RX       (RX),
        .BAUD     (BAUD),
        .EIGHT    (EIGHT),
        .PEN      (PEN),
        .OHEL     (OHEL),
        .READ_CLR (READ_CLR),
        .RX_DATA  (RX_DATA),
        .RXRDY    (RXRDY),
        .PERR     (PERR),
        .FERR     (FERR),
        .OVF      (OVF)
    );

    bit         line_q[$];
    bit         mdl_rdy;
    logic [7:0] mdl_data;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    function automatic bit line_at(input int m);
        return (m < line_q.size()) ? line_q[m] : 1'b1;
    endfunction

    task automatic build_line(input int baud, input bit eight, input bit pen, input bit par,
                              input logic [7:0] data, input bit stop);
        int nd;
        nd = eight ? 8 : 7;
        line_q.delete();
        repeat (baud + 1) line_q.push_back(1'b0);
        for (int k = 0; k < nd; k++) repeat (baud + 1) line_q.push_back(data[k]);
        if (pen) repeat (baud + 1) line_q.push_back(par);
        repeat (baud + 1) line_q.push_back(stop);
    endtask

    // Reference: read the line at the nominal sample instants and apply the frame rules
    function automatic void model(input int baud, input bit eight, input bit pen, input bit ohel,
                                  output bit valid, output logic [7:0] data,
                                  output bit perr, output bit ferr);
        int h, n, nd, ones;
        bit samples[9];
        bit par;
        h  = baud / 2;
        nd = eight ? 8 : 7;
        n  = nd + (pen ? 1 : 0);
        valid = (line_at(h + 1) == 1'b0);
        for (int k = 0; k < n; k++) samples[k] = line_at(h + 1 + (k + 1) * (baud + 1));
        data = 8'h00;
        for (int k = 0; k < nd; k++) data[k] = samples[k];
        par  = pen ? samples[n - 1] : 1'b0;
        ones = $countones(data) + (par ? 1 : 0);
        perr = pen && ((ones % 2) != (ohel ? 1 : 0));
        ferr = !line_at(h + 1 + (n + 1) * (baud + 1));
    endfunction

    task automatic run_frame(input string name, input int baud, input bit eight, input bit pen,
                             input bit ohel, input bit exp_valid, input logic [7:0] exp_data,
                             input bit exp_perr, input bit exp_ferr, input bit clr_at_load,
                             input int tail);
        int  n, load_idx, total;
        bit  exp_ovf, seen;
        n        = (eight ? 8 : 7) + (pen ? 1 : 0);
        load_idx = baud / 2 + 1 + (n + 1) * (baud + 1) + SL;
        exp_ovf  = mdl_rdy && !clr_at_load;
        total    = line_q.size() + tail;
        seen     = 1'b0;
        for (int m = 0; m < total; m++) begin
            @(negedge clk);
            if (m == 0) begin
                BAUD  = 19'(baud);
                EIGHT = eight;
                PEN   = pen;
                OHEL  = ohel;
            end
            RX       = line_at(m);
            READ_CLR = clr_at_load && exp_valid && (m == load_idx);
            @(posedge clk);
            #1;
            READ_CLR = 1'b0;
            if (exp_valid && !mdl_rdy && m == load_idx - 1)
                check_bit({name, " rdy_early"}, RXRDY, 1'b0);
            if (exp_valid && m == load_idx) begin
                seen = 1'b1;
                check_byte({name, " data"}, RX_DATA, exp_data);
                check_bit({name, " rdy"}, RXRDY, 1'b1);
                check_bit({name, " perr"}, PERR, exp_perr);
                check_bit({name, " ferr"}, FERR, exp_ferr);
                check_bit({name, " ovf"}, OVF, exp_ovf);
                $display("frame %s data=%02h rdy=%b perr=%b ferr=%b ovf=%b", name, RX_DATA, RXRDY, PERR, FERR, OVF);
            end
        end
        if (exp_valid) begin
            check_bit({name, " load_seen"}, seen, 1'b1);
            mdl_rdy  = 1'b1;
            mdl_data = exp_data;
        end else begin
            check_bit({name, " no_load_rdy"}, RXRDY, mdl_rdy);
            check_byte({name, " no_load_data"}, RX_DATA, mdl_data);
            $display("false start %s rdy=%b", name, RXRDY);
        end
    endtask

    task automatic do_clear(input string name);
        @(negedge clk);
        READ_CLR = 1'b1;
        @(posedge clk);
        #1;
        READ_CLR = 1'b0;
        check_bit({name, " clr_rdy"}, RXRDY, 1'b0);
        check_bit({name, " clr_perr"}, PERR, 1'b0);
        check_bit({name, " clr_ferr"}, FERR, 1'b0);
        check_bit({name, " clr_ovf"}, OVF, 1'b0);
        check_byte({name, " clr_data_hold"}, RX_DATA, mdl_data);
        $display("read_clr %s data=%02h", name, RX_DATA);
        mdl_rdy = 1'b0;
    endtask

    typedef struct {
        int         baud;
        bit         eight, pen, ohel, par;
        logic [7:0] data;
        bit         stop;
        logic [7:0] exp_data;
        bit         exp_perr, exp_ferr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int         baud;
        bit         eight, pen, ohel, par, stop, valid, p, f, clr;
        logic [7:0] data, d;

        vecs[0] = '{9, 1, 0, 0, 0, 8'hA5, 1, 8'hA5, 0, 0};
        vecs[1] = '{9, 0, 1, 0, 1, 8'h41, 1, 8'h41, 1, 0};
        vecs[2] = '{9, 0, 1, 0, 0, 8'h41, 1, 8'h41, 0, 0};
        vecs[3] = '{9, 1, 0, 0, 0, 8'h3C, 0, 8'h3C, 0, 1};
        vecs[4] = '{9, 1, 1, 1, 0, 8'h07, 1, 8'h07, 0, 0};
        vecs[5] = '{9, 1, 1, 1, 1, 8'h07, 1, 8'h07, 1, 0};
        vecs[6] = '{0, 1, 0, 0, 0, 8'h54, 1, 8'hAA, 0, 0};
        vecs[7] = '{9, 0, 0, 0, 0, 8'hB5, 1, 8'h35, 0, 0};

        mdl_rdy  = 1'b0;
        mdl_data = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check_byte("reset data", RX_DATA, 8'h00);
        check_bit("reset rdy", RXRDY, 1'b0);
        check_bit("reset perr", PERR, 1'b0);
        check_bit("reset ferr", FERR, 1'b0);
        check_bit("reset ovf", OVF, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            build_line(vecs[i].baud, vecs[i].eight, vecs[i].pen, vecs[i].par, vecs[i].data, vecs[i].stop);
            run_frame($sformatf("vec%0d", i), vecs[i].baud, vecs[i].eight, vecs[i].pen, vecs[i].ohel,
                      1'b1, vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_ferr, 1'b0,
                      2 * (vecs[i].baud + 1) + 6);
            do_clear($sformatf("vec%0d", i));
        end

        // False start: three low clocks, then a clean frame must still be received
        line_q.delete();
        repeat (3) line_q.push_back(1'b0);
        run_frame("false_start", 9, 1, 0, 0, 1'b0, 8'h00, 0, 0, 1'b0, 20);
        build_line(9, 1, 0, 0, 8'h55, 1);
        run_frame("after_fs", 9, 1, 0, 0, 1'b1, 8'h55, 0, 0, 1'b0, 24);
        do_clear("after_fs");

        // Back-to-back frames without and with a coincident read-clear
        build_line(9, 1, 0, 0, 8'h11, 1);
        run_frame("b2b_a", 9, 1, 0, 0, 1'b1, 8'h11, 0, 0, 1'b0, 0);
        build_line(9, 1, 0, 0, 8'h22, 1);
        run_frame("b2b_b", 9, 1, 0, 0, 1'b1, 8'h22, 0, 0, 1'b0, 24);
        do_clear("b2b");
        build_line(9, 1, 0, 0, 8'h11, 1);
        run_frame("b2b_c", 9, 1, 0, 0, 1'b1, 8'h11, 0, 0, 1'b0, 0);
        build_line(9, 1, 0, 0, 8'h22, 1);
        run_frame("b2b_clr", 9, 1, 0, 0, 1'b1, 8'h22, 0, 0, 1'b1, 24);

        // Reset during data bit 4 abandons the frame and clears the held character
        build_line(9, 1, 0, 0, 8'hFF, 1);
        for (int m = 0; m < 52; m++) begin
            @(negedge clk);
            RX = line_at(m);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_byte("midrst data", RX_DATA, 8'h00);
        check_bit("midrst rdy", RXRDY, 1'b0);
        check_bit("midrst perr", PERR, 1'b0);
        check_bit("midrst ferr", FERR, 1'b0);
        check_bit("midrst ovf", OVF, 1'b0);
        $display("reset mid-frame data=%02h rdy=%b", RX_DATA, RXRDY);
        RX = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        mdl_rdy  = 1'b0;
        mdl_data = 8'h00;
        repeat (60) @(negedge clk);
        check_bit("postrst rdy", RXRDY, 1'b0);
        check_byte("postrst data", RX_DATA, 8'h00);
        build_line(9, 1, 0, 0, 8'h81, 1);
        run_frame("postrst_81", 9, 1, 0, 0, 1'b1, 8'h81, 0, 0, 1'b0, 24);

        for (int i = 0; i < 24; i++) begin
            baud  = $urandom_range(0, 12);
            eight = 1'($urandom % 2);
            pen   = 1'($urandom % 2);
            ohel  = 1'($urandom % 2);
            par   = 1'($urandom % 2);
            stop  = ($urandom % 4) != 0;
            data  = 8'($urandom);
            if (baud == 0) data[0] = 1'b0;
            clr   = ($urandom % 3) == 0;
            build_line(baud, eight, pen, par, data, stop);
            model(baud, eight, pen, ohel, valid, d, p, f);
            run_frame($sformatf("rand%0d_b%0d", i, baud), baud, eight, pen, ohel,
                      valid, d, p, f, clr, 2 * (baud + 1) + 6);
            if ($urandom % 2) do_clear($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
